// File: rtl/regfile_sb_if.sv
// Decode/issue and writeback connection to the scoreboarded register file.
interface regfile_sb_if #(
    parameter int XLEN = 64,
    parameter int AW   = 5
);
    logic            clr_req;
    logic            ready;
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rd1_data;
    logic [XLEN-1:0] rd2_data;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            iss_en;
    logic [AW-1:0]   iss_addr;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;

    modport master (
        output clr_req, rs1_addr, rs2_addr, iss_en, iss_addr, wr_en, wr_addr, wr_data,
        input  ready, rd1_data, rd2_data, rs1_busy, rs2_busy
    );

    modport slave (
        input  clr_req, rs1_addr, rs2_addr, iss_en, iss_addr, wr_en, wr_addr, wr_data,
        output ready, rd1_data, rd2_data, rs1_busy, rs2_busy
    );
endinterface

// File: rtl/regfile_sb.sv
// Integer register file with two read ports, one write port, optional bypass,
// a pending-write scoreboard and a sequential clear engine.
module regfile_sb #(
    parameter  int XLEN   = 64,
    parameter  int NREGS  = 32,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_sb_if.slave  bus
);
    typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

    localparam logic [AW:0]   NREGS_W  = (AW+1)'(NREGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
    localparam logic [AW-1:0] IDX_ONE  = AW'(1);

    state_t            r_state;
    logic              r_ready;
    logic [AW-1:0]     r_clr_idx;
    logic [NREGS-1:0]  r_pending;
    logic [XLEN-1:0]   r_mem [NREGS];

    logic              w_wr_ok;
    logic              w_iss_ok;
    logic              w_byp1;
    logic              w_byp2;
    logic [NREGS-1:0]  w_pend_nxt;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (a != '0) && ({1'b0, a} < NREGS_W);
    endfunction

    assign w_wr_ok  = r_ready && bus.wr_en  && addr_ok(bus.wr_addr);
    assign w_iss_ok = r_ready && bus.iss_en && addr_ok(bus.iss_addr);
    assign w_byp1   = (BYPASS != 0) && w_wr_ok && (bus.wr_addr == bus.rs1_addr);
    assign w_byp2   = (BYPASS != 0) && w_wr_ok && (bus.wr_addr == bus.rs2_addr);
    assign bus.ready = r_ready;

    // Scoreboard next state: an issue to the same register wins over its writeback.
    always_comb begin
        w_pend_nxt = '0;
        for (int i = 1; i < NREGS; i++) begin
            w_pend_nxt[i] = (w_iss_ok && (bus.iss_addr == AW'(i))) ||
                            (r_pending[i] && !(w_wr_ok && (bus.wr_addr == AW'(i))));
        end
    end

    // Clear/ready FSM, ready flag and pending scoreboard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= IDX_ONE;
            r_ready   <= 1'b0;
            r_pending <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_pending <= '0;
                    if (r_clr_idx == LAST_IDX) begin
                        r_state   <= ST_READY;
                        r_ready   <= 1'b1;
                        r_clr_idx <= IDX_ONE;
                    end else begin
                        r_state   <= ST_CLEAR;
                        r_ready   <= 1'b0;
                        r_clr_idx <= r_clr_idx + IDX_ONE;
                    end
                end
                ST_READY: begin
                    if (bus.clr_req) begin
                        r_state   <= ST_CLEAR;
                        r_ready   <= 1'b0;
                        r_clr_idx <= IDX_ONE;
                        r_pending <= '0;
                    end else begin
                        r_state   <= ST_READY;
                        r_ready   <= 1'b1;
                        r_clr_idx <= IDX_ONE;
                        r_pending <= w_pend_nxt;
                    end
                end
                default: begin
                    r_state   <= ST_CLEAR;
                    r_ready   <= 1'b0;
                    r_clr_idx <= IDX_ONE;
                    r_pending <= '0;
                end
            endcase
        end
    end

    // Storage array; zeroed one entry per cycle by the clear engine, never reset directly.
    always_ff @(posedge clk) begin
        if (r_state == ST_CLEAR) begin
            r_mem[r_clr_idx] <= '0;
        end else if (w_wr_ok) begin
            r_mem[bus.wr_addr] <= bus.wr_data;
        end else begin
            r_mem[0] <= '0;
        end
    end

    // Read port 1 data and busy.
    always_comb begin
        bus.rd1_data = '0;
        bus.rs1_busy = 1'b0;
        if (!r_ready) begin
            bus.rd1_data = '0;
            bus.rs1_busy = 1'b0;
        end else if (w_byp1) begin
            bus.rd1_data = bus.wr_data;
            bus.rs1_busy = 1'b0;
        end else if (addr_ok(bus.rs1_addr)) begin
            bus.rd1_data = r_mem[bus.rs1_addr];
            bus.rs1_busy = r_pending[bus.rs1_addr];
        end else begin
            bus.rd1_data = '0;
            bus.rs1_busy = 1'b0;
        end
    end

    // Read port 2 data and busy.
    always_comb begin
        bus.rd2_data = '0;
        bus.rs2_busy = 1'b0;
        if (!r_ready) begin
            bus.rd2_data = '0;
            bus.rs2_busy = 1'b0;
        end else if (w_byp2) begin
            bus.rd2_data = bus.wr_data;
            bus.rs2_busy = 1'b0;
        end else if (addr_ok(bus.rs2_addr)) begin
            bus.rd2_data = r_mem[bus.rs2_addr];
            bus.rs2_busy = r_pending[bus.rs2_addr];
        end else begin
            bus.rd2_data = '0;
            bus.rs2_busy = 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: default build, a no-bypass build and a 24-register build share one stimulus.
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr_req = 1'b0;
    logic [4:0]  rs1 = 5'd0, rs2 = 5'd0, iss_addr = 5'd0, wr_addr = 5'd0;
    logic        iss_en = 1'b0, wr_en = 1'b0;
    logic [63:0] wr_data = 64'd0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_cyc, n_cyc2;

    regfile_sb_if #(.XLEN(64), .AW(5)) b0 ();
    regfile_sb_if #(.XLEN(64), .AW(5)) b1 ();
    regfile_sb_if #(.XLEN(64), .AW(5)) b2 ();

    assign {b0.clr_req, b0.rs1_addr, b0.rs2_addr, b0.iss_en, b0.iss_addr, b0.wr_en, b0.wr_addr, b0.wr_data} =
           {clr_req, rs1, rs2, iss_en, iss_addr, wr_en, wr_addr, wr_data};
    assign {b1.clr_req, b1.rs1_addr, b1.rs2_addr, b1.iss_en, b1.iss_addr, b1.wr_en, b1.wr_addr, b1.wr_data} =
           {clr_req, rs1, rs2, iss_en, iss_addr, wr_en, wr_addr, wr_data};
    assign {b2.clr_req, b2.rs1_addr, b2.rs2_addr, b2.iss_en, b2.iss_addr, b2.wr_en, b2.wr_addr, b2.wr_data} =
           {clr_req, rs1, rs2, iss_en, iss_addr, wr_en, wr_addr, wr_data};

    regfile_sb #(.XLEN(64), .NREGS(32), .BYPASS(1)) u_def   (.clk(clk), .rst_n(rst_n), .bus(b0));
    regfile_sb #(.XLEN(64), .NREGS(32), .BYPASS(0)) u_nobyp (.clk(clk), .rst_n(rst_n), .bus(b1));
    regfile_sb #(.XLEN(64), .NREGS(24), .BYPASS(1)) u_n24   (.clk(clk), .rst_n(rst_n), .bus(b2));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int c0, output int c2);
        c0 = 0;
        c2 = 0;
        do begin
            step();
            c0++;
            if (b2.ready === 1'b1 && c2 == 0) c2 = c0;
        end while (b0.ready !== 1'b1 && c0 < 200);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and initial clear
        repeat (2) step();
        #1;
        check("rst_ready", 64'(b0.ready), 64'd0);
        check("rst_rd1", b0.rd1_data, 64'd0);
        check("rst_busy", 64'(b0.rs1_busy), 64'd0);
        step();
        rst_n = 1'b1;
        rs1 = 5'd5;
        #1;
        check("clr_rd1", b0.rd1_data, 64'd0);
        wait_ready(n_cyc, n_cyc2);
        check("clr_cycles", 64'(n_cyc), 64'd31);
        check("clr_cycles_n24", 64'(n_cyc2), 64'd23);
        #1;
        check("post_clr_x5", b0.rd1_data, 64'd0);
        check("post_clr_busy", 64'(b0.rs1_busy), 64'd0);
        check("nobyp_ready", 64'(b1.ready), 64'd1);

        // Write x5 with and without bypass
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hDEADBEEF_CAFEF00D; rs2 = 5'd5;
        #1;
        check("byp_rd1", b0.rd1_data, 64'hDEADBEEF_CAFEF00D);
        check("nobyp_rd1", b1.rd1_data, 64'd0);
        step();
        wr_en = 1'b0;
        #1;
        check("x5_rd1", b0.rd1_data, 64'hDEADBEEF_CAFEF00D);
        check("x5_rd2", b0.rd2_data, 64'hDEADBEEF_CAFEF00D);
        check("nobyp_x5", b1.rd1_data, 64'hDEADBEEF_CAFEF00D);

        // x0 ignores writes and issues
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 64'd1; rs1 = 5'd0;
        #1;
        check("x0_byp", b0.rd1_data, 64'd0);
        step();
        wr_en = 1'b0; iss_en = 1'b1; iss_addr = 5'd0;
        #1;
        check("x0_rd", b0.rd1_data, 64'd0);
        check("x0_busy", 64'(b0.rs1_busy), 64'd0);
        step();
        iss_en = 1'b0;
        #1;
        check("x0_busy_iss", 64'(b0.rs1_busy), 64'd0);

        // Scoreboard on x7
        iss_en = 1'b1; iss_addr = 5'd7;
        step();
        iss_en = 1'b0; rs1 = 5'd7;
        #1;
        check("x7_busy", 64'(b0.rs1_busy), 64'd1);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h7777;
        #1;
        check("x7_busy_mask", 64'(b0.rs1_busy), 64'd0);
        check("x7_byp_data", b0.rd1_data, 64'h7777);
        check("x7_nobyp_busy", 64'(b1.rs1_busy), 64'd1);
        step();
        wr_en = 1'b0;
        #1;
        check("x7_busy_clr", 64'(b0.rs1_busy), 64'd0);
        check("x7_nobyp_busy_clr", 64'(b1.rs1_busy), 64'd0);
        check("x7_data", b0.rd1_data, 64'h7777);
        iss_en = 1'b1; iss_addr = 5'd7; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h7A7A;
        step();
        iss_en = 1'b0; wr_en = 1'b0;
        #1;
        check("x7_iss_wr_data", b0.rd1_data, 64'h7A7A);
        check("x7_iss_wr_busy", 64'(b0.rs1_busy), 64'd1);
        check("x7_iss_wr_busy_nb", 64'(b1.rs1_busy), 64'd1);

        // Fill x1..x31, then out-of-range access on the 24-register build
        for (int i = 1; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 5'(i); wr_data = 64'(i) * 64'h0101_0101_0101_0101;
            step();
        end
        wr_en = 1'b0; rs1 = 5'd31; rs2 = 5'd1;
        #1;
        check("fill_x31", b0.rd1_data, 64'h1F1F_1F1F_1F1F_1F1F);
        check("fill_x1", b0.rd2_data, 64'h0101_0101_0101_0101);
        check("n24_x31", b2.rd1_data, 64'd0);
        wr_en = 1'b1; wr_addr = 5'd30; wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        iss_en = 1'b1; iss_addr = 5'd30; rs1 = 5'd30; rs2 = 5'd23;
        #1;
        check("n24_x30_byp", b2.rd1_data, 64'd0);
        check("n24_x30_busy_byp", 64'(b2.rs1_busy), 64'd0);
        step();
        wr_en = 1'b0; iss_en = 1'b0;
        #1;
        check("n24_x30_rd", b2.rd1_data, 64'd0);
        check("n24_x30_busy", 64'(b2.rs1_busy), 64'd0);
        check("n24_x23", b2.rd2_data, 64'h1717_1717_1717_1717);
        check("def_x30", b0.rd1_data, 64'hFFFF_FFFF_FFFF_FFFF);
        rs2 = 5'd5;
        #1;
        check("n24_x5", b2.rd2_data, 64'h0505_0505_0505_0505);

        // Requested clear, with writes/issues/clr_req held during it
        iss_en = 1'b1; iss_addr = 5'd9; rs1 = 5'd9;
        step();
        iss_en = 1'b0;
        #1;
        check("x9_busy", 64'(b0.rs1_busy), 64'd1);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        #1;
        check("clrreq_ready", 64'(b0.ready), 64'd0);
        check("clrreq_rd", b0.rd1_data, 64'd0);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hABC;
        iss_en = 1'b1; iss_addr = 5'd9; clr_req = 1'b1;
        wait_ready(n_cyc, n_cyc2);
        wr_en = 1'b0; iss_en = 1'b0; clr_req = 1'b0; rs2 = 5'd3;
        #1;
        check("clrreq_cycles", 64'(n_cyc), 64'd31);
        check("clrreq_x9_busy", 64'(b0.rs1_busy), 64'd0);
        check("clrreq_x3", b0.rd2_data, 64'd0);
        for (int i = 0; i < 32; i++) begin
            step();
            rs1 = 5'(i);
            #1;
            check($sformatf("zero_x%0d", i), b0.rd1_data, 64'd0);
        end

        // Async reset from READY, then again mid-clear at clr_idx = 12
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 64'hF0; rs1 = 5'd31;
        step();
        wr_en = 1'b0;
        #1;
        check("x31_f0", b0.rd1_data, 64'hF0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_ready", 64'(b0.ready), 64'd0);
        step();
        rst_n = 1'b1;
        repeat (11) step();
        check("midclr_ready", 64'(b0.ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("midclr_rst_ready", 64'(b0.ready), 64'd0);
        step();
        rst_n = 1'b1;
        wait_ready(n_cyc, n_cyc2);
        #1;
        check("midclr_cycles", 64'(n_cyc), 64'd31);
        check("midclr_x31", b0.rd1_data, 64'd0);
        check("midclr_busy", 64'(b0.rs1_busy), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
